// File: rtl/bsg_counter_overflow_sched_pkg.sv
// Shared types for the overflow-safe job scheduler.
//   state_e : scheduler FSM states (IDLE / RUN / DONE)
//   rr_idx  : wrap-around index helper used by the round-robin picker
package bsg_counter_overflow_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // (base + off) mod n, kept in int so the caller can cast to its own width
  function automatic int rr_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/bsg_round_robin_pick.sv
// Round-robin picker: search starts at (last + 1) mod els_p and wraps.
//   reqs  : request vector
//   last  : index of the previous winner
//   grant : one-hot winner (zero when no request)
//   idx   : binary winner index (zero when no request)
//   any   : at least one request present
module bsg_round_robin_pick
  import bsg_counter_overflow_sched_pkg::*;
#(
  parameter int els_p = 4
) (
  input  logic [els_p-1:0]         reqs,
  input  logic [$clog2(els_p)-1:0] last,
  output logic [els_p-1:0]         grant,
  output logic [$clog2(els_p)-1:0] idx,
  output logic                     any
);

  localparam int lg_els_lp = $clog2(els_p);

  logic [lg_els_lp-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    // Offsets 1..els_p visit every requester once; the old winner comes last.
    for (int k = 1; k <= els_p; k++) begin
      cand = lg_els_lp'(rr_idx(int'(last), k, els_p));
      if (!any && reqs[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/bsg_counter_overflow_sched.sv
// Round-robin job scheduler with an overflow-free tick counter.
// Accepts one job at a time, counts tick_i pulses up to the latched length,
// then emits a one-cycle done pulse to the owner.
//   clk_i, reset_n_i : clock, async active-low reset
//   tick_i           : count enable while a job runs
//   v_i, len_i       : per-requester valid and length (slice i = requester i)
//   yumi_o           : one-hot accept pulse (combinational, IDLE only)
//   done_o           : one-hot completion pulse (DONE state)
//   busy_o           : job loaded and not yet finished
//   owner_o, count_o : current/last owner, elapsed ticks
// Optional: BSG_COUNTER_OVERFLOW_SCHED_CANCEL_EN adds cancel_i / cancelled_o.
module bsg_counter_overflow_sched
  import bsg_counter_overflow_sched_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       tick_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   len_i,
`ifdef BSG_COUNTER_OVERFLOW_SCHED_CANCEL_EN
  input  logic                       cancel_i,
  output logic [els_p-1:0]           cancelled_o,
`endif
  output logic [els_p-1:0]           yumi_o,
  output logic [els_p-1:0]           done_o,
  output logic                       busy_o,
  output logic [$clog2(els_p)-1:0]   owner_o,
  output logic [width_p-1:0]         count_o
);

  localparam int lg_els_lp = $clog2(els_p);

  state_e                          state_r, state_n;
  logic [width_p-1:0]              count_r, limit_r, len_pick;
  logic [lg_els_lp-1:0]            owner_r, last_r, pick_idx;
  logic [els_p-1:0]                pick_grant, owner_oh;
  logic                            pick_any, accept, tick_last, cancel;
  logic [els_p-1:0][width_p-1:0]   len_a;

  assign len_a    = len_i;
  assign len_pick = len_a[pick_idx];
  assign owner_oh = {{(els_p-1){1'b0}}, 1'b1} << owner_r;

  bsg_round_robin_pick #(.els_p(els_p)) u_pick (
    .reqs  (v_i),
    .last  (last_r),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Gate with reset so yumi_o stays low while reset is held, clock or not.
  assign accept = reset_n_i && (state_r == IDLE) && pick_any;

  // limit is nonzero in RUN, so limit-1 never wraps and count stops at limit.
  assign tick_last = (state_r == RUN) && tick_i && (count_r == limit_r - width_p'(1));

`ifdef BSG_COUNTER_OVERFLOW_SCHED_CANCEL_EN
  assign cancel      = (state_r == RUN) && cancel_i;
  assign cancelled_o = cancel ? owner_oh : '0;
`else
  assign cancel      = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    yumi_o  = '0;
    done_o  = '0;
    unique case (state_r)
      IDLE: if (accept) begin
        yumi_o  = pick_grant;
        state_n = (len_pick == '0) ? DONE : RUN;
      end
      // cancel has priority over a completing tick
      RUN: begin
        if (cancel)         state_n = IDLE;
        else if (tick_last) state_n = DONE;
      end
      DONE: begin
        done_o  = owner_oh;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
      limit_r <= '0;
      owner_r <= '0;
      last_r  <= lg_els_lp'(els_p - 1);
    end else begin
      if (accept) begin
        limit_r <= len_pick;
        count_r <= '0;
        owner_r <= pick_idx;
      end else if (state_r == RUN && tick_i && !cancel) begin
        count_r <= count_r + width_p'(1);
      end
      if (state_r == DONE || cancel) last_r <= owner_r;
    end
  end

  assign busy_o  = (state_r != IDLE);
  assign owner_o = owner_r;
  assign count_o = count_r;

endmodule

// File: tb/tb_bsg_counter_overflow_sched.sv
module tb_bsg_counter_overflow_sched;

  localparam int els_lp   = 4;
  localparam int width_lp = 8;

  logic                         clk = 1'b0;
  logic                         reset_n = 1'b0;
  logic                         tick = 1'b0;
  logic [els_lp-1:0]            v = '0;
  logic [els_lp*width_lp-1:0]   len = '0;
  logic [els_lp-1:0]            yumi, done;
  logic                         busy;
  logic [1:0]                   owner;
  logic [width_lp-1:0]          count;
`ifdef BSG_COUNTER_OVERFLOW_SCHED_CANCEL_EN
  logic                         cancel = 1'b0;
  logic [els_lp-1:0]            cancelled;
`endif

  always #5 clk = ~clk;

  bsg_counter_overflow_sched #(.els_p(els_lp), .width_p(width_lp)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .tick_i      (tick),
    .v_i         (v),
    .len_i       (len),
`ifdef BSG_COUNTER_OVERFLOW_SCHED_CANCEL_EN
    .cancel_i    (cancel),
    .cancelled_o (cancelled),
`endif
    .yumi_o      (yumi),
    .done_o      (done),
    .busy_o      (busy),
    .owner_o     (owner),
    .count_o     (count)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] v;
    logic [7:0] len;
    bit         gap;   // ticks only on cycles 3 and 7 after accept
    int         owner;
  } vec_t;

  typedef struct {
    int         owner;
    logic [7:0] len;
    int         lat;
  } exp_t;

  exp_t sb[$];

  // Entered at the start of a cycle (posedge+1) with the DUT idle; returns at
  // the start of the cycle after the done pulse.
  task automatic do_job(input vec_t t);
    bit   ok;
    int   cyc;
    exp_t e;
    v    = t.v;
    len  = {4{t.len}};
    tick = t.gap ? 1'b0 : 1'b1;
    @(negedge clk);
    chk("accept_yumi", yumi, 4'b0001 << t.owner);
    chk("accept_busy", busy, 0);
    chk("accept_no_done", done, 0);
    @(posedge clk); #1;
    v   = '0;
    len = $urandom;   // length must have been captured on the accept edge
    ok  = 0;
    for (cyc = 1; cyc <= 300; cyc++) begin
      if (t.gap) tick = (cyc == 3 || cyc == 7);
      @(negedge clk);
      if (done != 0) begin
        ok = 1;
        break;
      end
      if (!t.gap) chk("run_count", count, cyc - 1);
      if (t.gap && cyc == 4) chk("gap_count_after_tick3", count, 1);
      if (yumi != 0) chk("no_yumi_while_busy", yumi, 0);
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    if (ok) begin
      chk("done_onehot", done, 4'b0001 << e.owner);
      chk("done_count", count, e.len);
      chk("done_latency", cyc, e.lat);
      chk("done_busy", busy, 1);
      chk("done_no_yumi", yumi, 0);
    end else begin
      chk("done_timeout", 0, 1);
    end
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic push_run(input vec_t t);
    sb.push_back('{t.owner, t.len, t.gap ? 8 : int'(t.len) + 1});
    do_job(t);
  endtask

  vec_t tbl[11];

  initial begin
    bit found;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    tbl[0]  = '{4'b1111, 8'd1,   1'b0, 0};
    tbl[1]  = '{4'b1111, 8'd1,   1'b0, 1};
    tbl[2]  = '{4'b1111, 8'd1,   1'b0, 2};
    tbl[3]  = '{4'b1111, 8'd1,   1'b0, 3};
    tbl[4]  = '{4'b1111, 8'd1,   1'b0, 0};
    tbl[5]  = '{4'b0001, 8'd3,   1'b0, 0};
    tbl[6]  = '{4'b0100, 8'd0,   1'b0, 2};
    tbl[7]  = '{4'b1011, 8'd255, 1'b0, 3};
    tbl[8]  = '{4'b0010, 8'd2,   1'b1, 1};
    tbl[9]  = '{4'b1111, 8'd2,   1'b0, 2};
    tbl[10] = '{4'b0101, 8'd5,   1'b0, 0};

    // reset state, with requests pending and the clock running
    v = 4'b1111; tick = 1'b1;
    #3;
    chk("rst_yumi", yumi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_owner", owner, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_yumi", yumi, 0);
    chk("rst_hold_busy", busy, 0);
    @(posedge clk); #1;
    reset_n = 1'b1; v = '0; tick = 1'b0;

    foreach (tbl[i]) push_run(tbl[i]);

    // reset mid-job: drop silently, then requester 1 wins first
    v = 4'b0001; len = {4{8'd20}}; tick = 1'b1;
    @(negedge clk);
    chk("mid_accept_yumi", yumi, 4'b0001);
    @(posedge clk); #1;
    v = '0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (count == 8'd5) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("mid_reach_count5", found, 1);
    #1; reset_n = 1'b0; v = 4'b0110;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_yumi", yumi, 0);
    chk("mid_rst_done", done, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_no_done", done, 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; tick = 1'b0;
    push_run('{4'b0110, 8'd1, 1'b0, 1});

`ifdef BSG_COUNTER_OVERFLOW_SCHED_CANCEL_EN
    // cancel lands on the completing tick: cancel wins, no done pulse
    v = 4'b0100; len = {4{8'd2}}; tick = 1'b1;
    @(negedge clk);
    chk("cxl_accept_yumi", yumi, 4'b0100);
    @(posedge clk); #1;
    v = '0;
    @(posedge clk); #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cxl_pulse", cancelled, 4'b0100);
    chk("cxl_no_done", done, 0);
    @(posedge clk); #1;
    cancel = 1'b0; tick = 1'b0;
    @(negedge clk);
    chk("cxl_after_done", done, 0);
    chk("cxl_after_busy", busy, 0);
    chk("cxl_after_pulse", cancelled, 0);
    @(posedge clk); #1;
    push_run('{4'b1111, 8'd1, 1'b0, 3});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/bsg_counter_overflow_sched.md
BSG_COUNTER_OVERFLOW_SCHED -- requirements
Module: bsg_counter_overflow_sched

Interface
REQ-001 The block SHALL have parameter els_p, default 4: number of requesters; legal range 2..16.
REQ-002 The block SHALL have parameter width_p, default 32: width of the count and of each job length.
REQ-003 The block SHALL have the following ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- tick_i  in  1  count-enable pulse; advances the running job.
- v_i  in  els_p  per-requester job-valid; held high until accepted.
- len_i  in  els_p*width_p  per-requester job length in ticks; slice i belongs to requester i.
- yumi_o  out  els_p  one-hot acceptance pulse.
- done_o  out  els_p  one-hot completion pulse.
- busy_o  out  1  high when a job is loaded and not yet completed.
- owner_o  out  $clog2(els_p)  index of the current or last job owner.
- count_o  out  width_p  elapsed ticks of the current job.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-005 IDLE behaviour:
- If any v_i bit is high, the block SHALL pick one requester by round-robin.
- Priority SHALL start at (last_owner+1) mod els_p.
- yumi_o[pick] SHALL be high combinationally in that same cycle.
- The block SHALL latch limit=len_i[pick], set count_o=0 and owner_o=pick.
REQ-006 IDLE->RUN SHALL occur when the accepted len is nonzero; IDLE->DONE SHALL occur when the accepted len==0.
REQ-007 RUN behaviour:
- Each cycle with tick_i=1, count_o SHALL increment by 1.
- When count_o+1==limit on a tick, the block SHALL go to DONE with count_o==limit.
- tick_i SHALL be ignored in IDLE and DONE.
REQ-008 DONE behaviour:
- done_o[owner_o] SHALL be high for exactly one cycle.
- last_owner SHALL be set to owner_o.
- The next state SHALL be IDLE.
REQ-009 busy_o SHALL be high in RUN and DONE, and low in IDLE.
REQ-010 yumi_o and done_o SHALL never be high in the same cycle, and each SHALL be at most one-hot.
REQ-011 Latency: the done pulse SHALL occur exactly one cycle after the cycle holding the limit-th tick; a len==0 job SHALL complete one cycle after acceptance.
REQ-012 After DONE, the earliest next acceptance SHALL be the following IDLE cycle, giving a minimum job spacing of limit+2 cycles with tick_i tied high.
REQ-013 Arithmetic:
- count_o SHALL never exceed limit.
- len = 2^width_p-1 SHALL complete without wrap.
- No count overflow SHALL be possible.
REQ-014 v_i deasserted without an accept SHALL be legal and SHALL be ignored; len_i SHALL be sampled only on the accept cycle.

Reset
REQ-015 While reset_n_i is low, regardless of clk_i, the block SHALL hold: state=IDLE, count_o=0, owner_o=0, last_owner=els_p-1 (requester 0 has first priority), yumi_o=0, done_o=0, busy_o=0.
REQ-016 Reset asserted mid-job SHALL drop the job silently, with no done_o pulse.
REQ-017 Reset deassertion SHALL be synchronized externally; the first accept can occur on the first clk_i edge after release.

Configuration
REQ-018 With macro BSG_COUNTER_OVERFLOW_SCHED_CANCEL_EN defined, the block SHALL add:
- input cancel_i (1 bit)
- output cancelled_o (els_p bits)
REQ-019 With BSG_COUNTER_OVERFLOW_SCHED_CANCEL_EN defined, cancel_i=1 in RUN SHALL:
- move the FSM to IDLE;
- pulse cancelled_o[owner_o] for one cycle;
- suppress done_o;
- update last_owner.
REQ-020 With BSG_COUNTER_OVERFLOW_SCHED_CANCEL_EN defined:
- cancel SHALL win over a simultaneous completing tick;
- cancel_i SHALL be ignored in IDLE and DONE.
REQ-021 Without BSG_COUNTER_OVERFLOW_SCHED_CANCEL_EN, neither port SHALL exist and behaviour SHALL be exactly REQ-004..017.

Structure
REQ-022 The state enum typedef (IDLE/RUN/DONE) SHALL live in shared package bsg_counter_overflow_sched_pkg.
REQ-023 The round-robin selection SHALL be a sub-module bsg_round_robin_pick, with interface (reqs, last pointer) -> (one-hot grant, index, any).

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Single job, els_p=4: v_i=0001, len=3, tick_i=1 -> yumi_o=0001 at cycle 0, count_o 1,2,3 at cycles 1-3, done_o=0001 at cycle 4, busy_o low at cycle 5.
- Round-robin fairness: v_i=1111 held, all len=1 -> acceptance order 0,1,2,3,0; each done_o precedes the next yumi_o.
- Zero and max length: len=0 -> done_o one cycle after accept, count_o=0. With width_p=8, len=255 -> done_o after 255 ticks, count_o=255, no wrap.
- Gapped ticks: len=2, tick_i high only on cycles 3 and 7 -> count_o=1 from cycle 4, done_o at cycle 8.
- Reset mid-job: reset_n_i low during RUN with count_o=5 -> all outputs 0 immediately, no done_o. After release, v_i=0110 -> requester 1 accepted first.
- Cancel (CANCEL_EN): cancel_i and the final tick in the same cycle -> cancelled_o pulses, done_o stays 0, next acceptance goes to owner+1.
